// File: rtl/alarm_trigger.sv
// ============================================================================
// Module      : alarm_trigger
// Description : Compares the running time with the stored alarm. It rings a
//               pulsed buzzer and handles the stop, snooze and timeout cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_trigger #(
   parameter int RING_TIMEOUT_S = 60,
   parameter int SNOOZE_S       = 300,
   parameter int MAX_SNOOZE     = 3,
   parameter int CNT_W          = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic [1:0] time_hours_left,
   input  logic [3:0] time_hours_right,
   input  logic [2:0] time_minutes_left,
   input  logic [3:0] time_minutes_right,
   input  logic [1:0] alarm_hours_left,
   input  logic [3:0] alarm_hours_right,
   input  logic [2:0] alarm_minutes_left,
   input  logic [3:0] alarm_minutes_right,
   input  logic       alarm_on,
   input  logic       set_alarm_en,
   input  logic       stop_button,
   input  logic       snooze_button,
   output logic       buzzer,
   output logic       ringing,
   output logic       snooze_active,
   output logic [1:0] snooze_count
);

   localparam logic [CNT_W-1:0] C_RING_LAST  = CNT_W'(RING_TIMEOUT_S - 1);
   localparam logic [CNT_W-1:0] C_SNZ_LAST   = CNT_W'(SNOOZE_S - 1);
   localparam logic [1:0]       C_MAX_SNOOZE = 2'(MAX_SNOOZE);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] sec_cnt_q;
   logic             buzzer_q;
   logic             ringing_q;
   logic             snooze_active_q;
   logic [1:0]       snooze_count_q;
   logic             match_q;

   logic             match;
   logic             trigger;
   logic             user_stop;
   logic [CNT_W-1:0] sec_inc;

   assign match = (time_hours_left    == alarm_hours_left)    &&
                  (time_hours_right   == alarm_hours_right)   &&
                  (time_minutes_left  == alarm_minutes_left)  &&
                  (time_minutes_right == alarm_minutes_right) &&
                  alarm_on && !set_alarm_en;
   assign trigger   = match & ~match_q;
   assign user_stop = stop_button | ~alarm_on;
   assign sec_inc   = (&sec_cnt_q) ? sec_cnt_q : sec_cnt_q + 1'b1;

   // ringing/snooze_active are registered together with the state they decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         sec_cnt_q       <= '0;
         buzzer_q        <= 1'b0;
         ringing_q       <= 1'b0;
         snooze_active_q <= 1'b0;
         snooze_count_q  <= 2'd0;
         match_q         <= 1'b1;
      end else begin
         match_q <= match;
         if (set_alarm_en) begin
            state_q         <= IDLE;
            sec_cnt_q       <= '0;
            buzzer_q        <= 1'b0;
            ringing_q       <= 1'b0;
            snooze_active_q <= 1'b0;
            snooze_count_q  <= 2'd0;
         end else begin
            case (state_q)
               IDLE: begin
                  buzzer_q <= 1'b0;
                  if (trigger) begin
                     state_q   <= RINGING;
                     ringing_q <= 1'b1;
                     buzzer_q  <= 1'b1;
                     sec_cnt_q <= '0;
                  end
               end
               RINGING: begin
                  if (tick_1hz) begin
                     buzzer_q  <= ~buzzer_q;
                     sec_cnt_q <= sec_inc;
                  end
                  if (user_stop) begin
                     state_q        <= IDLE;
                     ringing_q      <= 1'b0;
                     buzzer_q       <= 1'b0;
                     snooze_count_q <= 2'd0;
                  end else if (snooze_button && (snooze_count_q < C_MAX_SNOOZE)) begin
                     state_q         <= SNOOZE;
                     ringing_q       <= 1'b0;
                     snooze_active_q <= 1'b1;
                     buzzer_q        <= 1'b0;
                     sec_cnt_q       <= '0;
                     snooze_count_q  <= snooze_count_q + 2'd1;
                  end else if (tick_1hz && (sec_cnt_q == C_RING_LAST)) begin
                     state_q        <= IDLE;
                     ringing_q      <= 1'b0;
                     buzzer_q       <= 1'b0;
                     snooze_count_q <= 2'd0;
                  end
               end
               SNOOZE: begin
                  buzzer_q <= 1'b0;
                  if (tick_1hz) sec_cnt_q <= sec_inc;
                  if (user_stop) begin
                     state_q         <= IDLE;
                     snooze_active_q <= 1'b0;
                     snooze_count_q  <= 2'd0;
                  end else if (tick_1hz && (sec_cnt_q == C_SNZ_LAST)) begin
                     state_q         <= RINGING;
                     snooze_active_q <= 1'b0;
                     ringing_q       <= 1'b1;
                     buzzer_q        <= 1'b1;
                     sec_cnt_q       <= '0;
                  end
               end
               default: begin
                  state_q         <= IDLE;
                  ringing_q       <= 1'b0;
                  snooze_active_q <= 1'b0;
                  buzzer_q        <= 1'b0;
               end
            endcase
         end
      end
   end

   assign buzzer        = buzzer_q;
   assign ringing       = ringing_q;
   assign snooze_active = snooze_active_q;
   assign snooze_count  = snooze_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alarm_trigger.sv
// ============================================================================
// Module      : tb_alarm_trigger
// Description : Directed scoreboard bench for alarm_trigger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alarm_trigger;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_1hz = 1'b0;
   logic [1:0] thl = '0;
   logic [3:0] thr = '0;
   logic [2:0] tml = '0;
   logic [3:0] tmr = '0;
   logic [1:0] ahl = '0;
   logic [3:0] ahr = '0;
   logic [2:0] aml = '0;
   logic [3:0] amr = '0;
   logic       alarm_on = 1'b0;
   logic       set_alarm_en = 1'b0;
   logic       stop_b = 1'b0;
   logic       snooze_b = 1'b0;
   logic       buzzer, ringing, snooze_active;
   logic [1:0] snooze_count;

   alarm_trigger #(
      .RING_TIMEOUT_S(4),
      .SNOOZE_S      (3),
      .MAX_SNOOZE    (2),
      .CNT_W         (9)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .tick_1hz           (tick_1hz),
      .time_hours_left    (thl),
      .time_hours_right   (thr),
      .time_minutes_left  (tml),
      .time_minutes_right (tmr),
      .alarm_hours_left   (ahl),
      .alarm_hours_right  (ahr),
      .alarm_minutes_left (aml),
      .alarm_minutes_right(amr),
      .alarm_on           (alarm_on),
      .set_alarm_en       (set_alarm_en),
      .stop_button        (stop_b),
      .snooze_button      (snooze_b),
      .buzzer             (buzzer),
      .ringing            (ringing),
      .snooze_active      (snooze_active),
      .snooze_count       (snooze_count)
   );

   always #5 clk = ~clk;

   // Expected vector layout: {buzzer, ringing, snooze_active, snooze_count}
   typedef struct {
      logic [4:0] exp;
      string      name;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         logic [4:0] act;
         e   = q.pop_front();
         act = {buzzer, ringing, snooze_active, snooze_count};
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got b/r/s/cnt=%b required %b", e.name, act, e.exp);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      tick_1hz = 1'b0;
      stop_b   = 1'b0;
      snooze_b = 1'b0;
   endtask

   task automatic expect_o(input string n, input logic b, input logic r,
                           input logic s, input logic [1:0] c);
      exp_t e;
      e.exp  = {b, r, s, c};
      e.name = n;
      q.push_back(e);
   endtask

   task automatic set_time(input int hh, input int mm);
      thl = 2'(hh / 10);
      thr = 4'(hh % 10);
      tml = 3'(mm / 10);
      tmr = 4'(mm % 10);
   endtask

   task automatic tick_chk(input string n, input logic b, input logic r,
                           input logic s, input logic [1:0] c);
      tick_1hz = 1'b1;
      step();
      expect_o(n, b, r, s, c);
   endtask

   // Steps away from 07:30 and back to create a fresh match edge.
   task automatic retrigger(input string n);
      set_time(7, 31);
      step();
      set_time(7, 30);
      step();
      expect_o(n, 1'b1, 1'b1, 1'b0, 2'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1);
   end

   initial begin
      ahl = 2'd0; ahr = 4'd7; aml = 3'd3; amr = 4'd0;
      alarm_on = 1'b1;
      set_time(7, 29);
      rst = 1'b1;
      step();
      step();
      expect_o("reset", 0, 0, 0, 2'd0);
      rst = 1'b0;
      step();
      expect_o("idle_0729", 0, 0, 0, 2'd0);

      // Trigger and buzzer toggling, then stop with the time held
      set_time(7, 30);
      step();
      expect_o("trigger", 1, 1, 0, 2'd0);
      tick_chk("ring_tick1", 0, 1, 0, 2'd0);
      tick_chk("ring_tick2", 1, 1, 0, 2'd0);
      stop_b = 1'b1;
      step();
      expect_o("stop", 0, 0, 0, 2'd0);
      for (int i = 0; i < 10; i++) tick_chk("no_retrigger", 0, 0, 0, 2'd0);

      // Timeout on the fourth tick
      retrigger("trig_timeout");
      tick_chk("to_tick1", 0, 1, 0, 2'd0);
      tick_chk("to_tick2", 1, 1, 0, 2'd0);
      tick_chk("to_tick3", 0, 1, 0, 2'd0);
      tick_chk("to_tick4_idle", 0, 0, 0, 2'd0);

      // Snooze limit
      retrigger("trig_snooze");
      snooze_b = 1'b1;
      step();
      expect_o("snooze1", 0, 0, 1, 2'd1);
      tick_chk("snz1_tick1", 0, 0, 1, 2'd1);
      tick_chk("snz1_tick2", 0, 0, 1, 2'd1);
      tick_chk("snz1_tick3_ring", 1, 1, 0, 2'd1);
      snooze_b = 1'b1;
      step();
      expect_o("snooze2", 0, 0, 1, 2'd2);
      tick_chk("snz2_tick1", 0, 0, 1, 2'd2);
      snooze_b = 1'b1;
      step();
      expect_o("snooze_in_snooze_ignored", 0, 0, 1, 2'd2);
      tick_chk("snz2_tick2", 0, 0, 1, 2'd2);
      tick_chk("snz2_tick3_ring", 1, 1, 0, 2'd2);
      snooze_b = 1'b1;
      step();
      expect_o("snooze3_ignored", 1, 1, 0, 2'd2);
      tick_chk("lim_tick1", 0, 1, 0, 2'd2);
      tick_chk("lim_tick2", 1, 1, 0, 2'd2);
      tick_chk("lim_tick3", 0, 1, 0, 2'd2);
      tick_chk("lim_timeout", 0, 0, 0, 2'd0);

      // Stop beats snooze
      retrigger("trig_priority");
      stop_b   = 1'b1;
      snooze_b = 1'b1;
      step();
      expect_o("stop_over_snooze", 0, 0, 0, 2'd0);

      // Cancel during snooze; a match under edit never rings
      retrigger("trig_cancel");
      snooze_b = 1'b1;
      step();
      expect_o("cancel_snooze", 0, 0, 1, 2'd1);
      set_alarm_en = 1'b1;
      step();
      expect_o("cancel_idle", 0, 0, 0, 2'd0);
      set_time(7, 31);
      step();
      set_time(7, 30);
      step();
      expect_o("edit_match_silent", 0, 0, 0, 2'd0);
      set_time(7, 31);
      step();
      set_alarm_en = 1'b0;
      step();
      expect_o("edit_release", 0, 0, 0, 2'd0);

      // alarm_on dropping while ringing
      retrigger("trig_alarm_off");
      alarm_on = 1'b0;
      step();
      expect_o("alarm_off_idle", 0, 0, 0, 2'd0);
      set_time(7, 31);
      alarm_on = 1'b1;
      step();

      // Reset mid-ring, then release while the time still matches
      retrigger("trig_reset");
      rst = 1'b1;
      step();
      expect_o("reset_mid_ring", 0, 0, 0, 2'd0);
      rst = 1'b0;
      step();
      expect_o("release_no_ring", 0, 0, 0, 2'd0);
      tick_chk("release_hold", 0, 0, 0, 2'd0);
      retrigger("ring_after_reset");

      @(negedge clk);
      @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
